// File: rtl/caixa_dagua_pkg.sv
// Shared types and level constants for the water-tank controller.
// Pure declarations; no logic, no latency.
package caixa_dagua_pkg;

    localparam int                 LEVEL_W   = 3;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILLING,
        ST_FAULT
    } estado_t;

endpackage

// File: rtl/contador_ticks.sv
// Modulo-N tick counter: wrap is a same-cycle pulse on the enabled count that reaches N.
// Clear has priority over enable; no backpressure, the count simply holds when disabled.
module contador_ticks #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/controle_caixa_dagua.sv
// Water-tank level model with hysteretic pump control and supply-fault detection.
// Level steps land on the tick edge completing a count; FSM reacts one clock later.
module controle_caixa_dagua
    import caixa_dagua_pkg::*;
#(
    parameter int FILL_TICKS  = 4,
    parameter int DRAIN_TICKS = 2,
    parameter int LOW_MARK    = 2,
    parameter int FAULT_TICKS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               consume,
    input  logic               supply_ok,
    output logic [LEVEL_W-1:0] water_level,
    output logic               pump_on,
    output logic               consume_ok,
    output logic               full,
    output logic               fault
);

    localparam int                 NW        = $clog2(FAULT_TICKS + 1);
    localparam logic [NW-1:0]      NOSUP_MAX = NW'(FAULT_TICKS);
    localparam logic [LEVEL_W-1:0] LOW_LVL   = LEVEL_W'(LOW_MARK);

    estado_t            state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [NW-1:0]      nosup_q, nosup_d;
    logic               step_up, step_dn;
    logic               filling, empty;

    assign filling = (state_q == ST_FILLING);
    assign empty   = (level_q == '0);

    contador_ticks #(.N(FILL_TICKS)) u_fill (
        .clk   (clk),
        .reset (reset),
        .en    (tick && filling && supply_ok),
        .clr   (!filling),
        .wrap  (step_up)
    );

    contador_ticks #(.N(DRAIN_TICKS)) u_drain (
        .clk   (clk),
        .reset (reset),
        .en    (tick && consume && !empty),
        .clr   (!consume || empty),
        .wrap  (step_dn)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        nosup_d = nosup_q;

        case (state_q)
            ST_IDLE:    if (level_q <= LOW_LVL) state_d = ST_FILLING;
            ST_FILLING: begin
                if (level_q == LEVEL_MAX)       state_d = ST_IDLE;
                else if (nosup_q == NOSUP_MAX)  state_d = ST_FAULT;
            end
            ST_FAULT:   if (supply_ok)          state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase

        // Saturates so a sustained outage holds at the threshold until the FSM leaves FILLING.
        if (!filling || supply_ok) begin
            nosup_d = '0;
        end else if (tick && (nosup_q != NOSUP_MAX)) begin
            nosup_d = nosup_q + NW'(1);
        end

        // Simultaneous fill and drain steps cancel.
        if (step_up && !step_dn && (level_q != LEVEL_MAX)) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (step_dn && !step_up && !empty) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            level_q <= LEVEL_MAX;
            nosup_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            nosup_q <= nosup_d;
        end
    end

    assign water_level = level_q;
    assign pump_on     = filling;
    assign consume_ok  = !empty;
    assign full        = (level_q == LEVEL_MAX);
    assign fault       = (state_q == ST_FAULT);

endmodule
